// File: rtl/uart_rx_os_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_os_pkg
// Description : Shared state encodings and baud-divider defaults for the
//               oversampling UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_os_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_BRK   = 3'd5
  } rx_state_e;

  // Board clock / 115200 baud, and a short divider for fast simulation.
  localparam int c_baud_div_board = 104;
  localparam int c_baud_div_sim   = 16;

endpackage : uart_rx_os_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for the serial line; resets to the
//               idle (high) level so reset never looks like a start bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
  input  logic clk,
  input  logic rstn,
  input  logic i_rx,
  output logic o_rx_s
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
    end
  end

  assign o_rx_s = r_sync;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_os
// Description : Oversampling UART receiver with mid-bit sampling, glitch
//               rejection, framing/overrun flags and a one-entry holding
//               register on a valid/ready interface.
//               Optional parity: define UART_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os
  import uart_rx_os_pkg::*;
#(
  parameter int BAUD_DIV   = c_baud_div_board,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  output logic                 valid,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 ovr_clr
);

  localparam int c_baud_w = $clog2(BAUD_DIV);
  localparam int c_bit_w  = $clog2(DATA_BITS + 1);

  localparam logic [c_baud_w-1:0] c_baud_reload = c_baud_w'(BAUD_DIV - 1);
  localparam logic [c_baud_w-1:0] c_baud_half   = c_baud_w'(BAUD_DIV / 2 - 1);
  localparam logic [c_bit_w-1:0]  c_last_data   = c_bit_w'(DATA_BITS - 1);
  localparam logic [c_bit_w-1:0]  c_last_stop   = c_bit_w'(STOP_BITS - 1);

  generate
    if (BAUD_DIV < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
      $error("uart_rx_os: parameter out of range");
    end
  endgenerate

  rx_state_e             r_state;
  rx_state_e             w_state_nxt;
  logic                  w_rx_s;
  logic [c_baud_w-1:0]   r_baud_cnt;
  logic                  w_tick;
  logic [c_bit_w-1:0]    r_bit_cnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_ferr_acc;
  logic                  r_commit;
  logic                  w_par_err;

  logic                  w_load_half;
  logic                  w_shift_en;
  logic                  w_stop_en;
  logic                  w_bit_inc;
  logic                  w_bit_clr;
  logic                  w_commit_nxt;
`ifdef UART_RX_PARITY_EN
  logic                  w_par_en;
  logic                  r_par_bit;
`endif

  logic                  r_valid;
  logic [DATA_BITS-1:0]  r_data;
  logic                  r_frame_err;
  logic                  r_parity_err;
  logic                  r_overrun;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rstn   (rstn),
    .i_rx   (rx),
    .o_rx_s (w_rx_s)
  );

  assign w_tick = (r_baud_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load_half  = 1'b0;
    w_shift_en   = 1'b0;
    w_stop_en    = 1'b0;
    w_bit_inc    = 1'b0;
    w_bit_clr    = 1'b0;
    w_commit_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_en     = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_load_half = 1'b1;
          w_bit_clr   = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        // Start bit must still be low at mid-bit, otherwise it was a glitch.
        if (w_tick) begin
          w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == c_last_data) begin
            w_bit_clr   = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_state_nxt = ST_PAR;
`else
            w_state_nxt = ST_STOP;
`endif
          end else begin
            w_bit_inc = 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PAR: begin
        if (w_tick) begin
          w_par_en    = 1'b1;
          w_state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          w_stop_en = 1'b1;
          if (r_bit_cnt == c_last_stop) begin
            w_bit_clr    = 1'b1;
            w_commit_nxt = 1'b1;
            w_state_nxt  = (r_ferr_acc || !w_rx_s) ? ST_BRK : ST_IDLE;
          end else begin
            w_bit_inc = 1'b1;
          end
        end
      end
      ST_BRK: begin
        // Hold off until the line goes idle so a break is not re-read as data.
        if (w_rx_s) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_ferr_acc <= 1'b0;
      r_commit   <= 1'b0;
    end else begin
      if (w_load_half) begin
        r_baud_cnt <= c_baud_half;
      end else if (w_tick) begin
        r_baud_cnt <= c_baud_reload;
      end else begin
        r_baud_cnt <= r_baud_cnt - 1'b1;
      end

      if (w_bit_clr) begin
        r_bit_cnt <= '0;
      end else if (w_bit_inc) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (w_shift_en) begin
        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
      end

      if (w_load_half) begin
        r_ferr_acc <= 1'b0;
      end else if (w_stop_en) begin
        r_ferr_acc <= r_ferr_acc | ~w_rx_s;
      end

      r_commit <= w_commit_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_par_bit <= 1'b0;
    end else if (w_par_en) begin
      r_par_bit <= w_rx_s;
    end
  end

  assign w_par_err = ((^r_shift) ^ r_par_bit) != 1'(PARITY_ODD);
`else
  assign w_par_err = 1'b0;
`endif

  // Holding register: a commit while the held word is still unread drops the new word.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (r_commit) begin
        if (!r_valid || ready) begin
          r_valid      <= 1'b1;
          r_data       <= r_shift;
          r_frame_err  <= r_ferr_acc;
          r_parity_err <= w_par_err;
        end
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end

      if (r_commit && r_valid && !ready) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign valid      = r_valid;
  assign data       = r_data;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;

endmodule : uart_rx_os
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_os
// Description : Scoreboard bench for uart_rx_os; frames are queued as they are
//               driven and monitors compare each word as it is handed over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os;

  localparam int B = 16;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT1 = 2 + B/2 + (8 + P + 1) * B + 1;
  localparam int LAT2 = 2 + B/2 + (7 + P + 2) * B + 1;

  typedef struct {
    logic [8:0] data;
    logic       ferr;
    logic       perr;
    bit         chk_lat;
    int         exp_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx1, ready1, ovr_clr1, valid1, ferr1, perr1, ovr1;
  logic [7:0] data1;
  logic       rx2, ready2, ovr_clr2, valid2, ferr2, perr2, ovr2;
  logic [6:0] data2;

  exp_t q1[$];
  exp_t q2[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_os #(.BAUD_DIV(B), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .rx(rx1), .valid(valid1), .ready(ready1), .data(data1),
    .frame_err(ferr1), .parity_err(perr1), .overrun(ovr1), .ovr_clr(ovr_clr1)
  );

  uart_rx_os #(.BAUD_DIV(B), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) u_dut2 (
    .clk(clk), .rstn(rstn), .rx(rx2), .valid(valid2), .ready(ready2), .data(data2),
    .frame_err(ferr2), .parity_err(perr2), .overrun(ovr2), .ovr_clr(ovr_clr2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_bit(input int which, input logic v);
    if (which == 1) rx1 = v; else rx2 = v;
    repeat (B) @(posedge clk);
    #1;
  endtask

  function automatic logic good_par(input logic [8:0] d, input int nbits, input int odd);
    logic p;
    p = odd[0];
    for (int i = 0; i < nbits; i++) p ^= d[i];
    return p;
  endfunction

  // Drives one frame starting #1 after a clock edge; leaves the line at the stop level.
  task automatic frame(input int which, input logic [8:0] d, input int nbits, input int nstop,
                       input logic stop_v, input logic par_v, input int odd,
                       input bit push, input bit chk_lat, input int lat);
    exp_t e;
    logic p;
    @(posedge clk);
    #1;
    p = par_v;
    e.data = '0;
    for (int i = 0; i < nbits; i++) begin
      e.data[i] = d[i];
      p ^= d[i];
    end
    e.ferr    = ~stop_v;
    e.perr    = (P == 1) ? (p != odd[0]) : 1'b0;
    e.chk_lat = chk_lat;
    e.exp_cyc = cyc + 1 + lat;
    if (push) begin
      if (which == 1) q1.push_back(e); else q2.push_back(e);
    end
    drive_bit(which, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(which, d[i]);
    if (P == 1) drive_bit(which, par_v);
    for (int i = 0; i < nstop; i++) drive_bit(which, stop_v);
  endtask

  always @(negedge clk) begin
    if (rstn && valid1 && ready1) begin
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL dut1 unexpected word: got data 0x%0h, expected no word", data1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("dut1 data", 32'(data1), 32'(e.data));
        check("dut1 frame_err", 32'(ferr1), 32'(e.ferr));
        check("dut1 parity_err", 32'(perr1), 32'(e.perr));
        if (e.chk_lat) check("dut1 latency cycle", 32'(cyc), 32'(e.exp_cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && valid2 && ready2) begin
      if (q2.size() == 0) begin
        n_chk++;
        $display("FAIL dut2 unexpected word: got data 0x%0h, expected no word", data2);
      end else begin
        exp_t e;
        e = q2.pop_front();
        check("dut2 data", 32'(data2), 32'(e.data));
        check("dut2 frame_err", 32'(ferr2), 32'(e.ferr));
        check("dut2 parity_err", 32'(perr2), 32'(e.perr));
        if (e.chk_lat) check("dut2 latency cycle", 32'(cyc), 32'(e.exp_cyc));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got %0d/%0d checks by time limit, expected completion", n_pass, n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0;
    rx1 = 1'b1; ready1 = 1'b1; ovr_clr1 = 1'b0;
    rx2 = 1'b1; ready2 = 1'b1; ovr_clr2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset valid1", 32'(valid1), 0);
    check("reset data1", 32'(data1), 0);
    check("reset frame_err1", 32'(ferr1), 0);
    check("reset parity_err1", 32'(perr1), 0);
    check("reset overrun1", 32'(ovr1), 0);
    check("reset valid2", 32'(valid2), 0);
    check("reset data2", 32'(data2), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (5) @(posedge clk);

    // Clean frame with latency check.
    frame(1, 9'h0A5, 8, 1, 1'b1, good_par(9'h0A5, 8, 1), 1, 1'b1, 1'b1, LAT1);
    repeat (2*B) @(posedge clk);

    // Start-bit glitch, then a normal frame.
    #1;
    rx1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx1 = 1'b1;
    repeat (3*B) @(posedge clk);
    frame(1, 9'h03C, 8, 1, 1'b1, good_par(9'h03C, 8, 1), 1, 1'b1, 1'b1, LAT1);
    repeat (2*B) @(posedge clk);

    // Bad stop bit followed by a held-low line.
    frame(1, 9'h081, 8, 1, 1'b0, good_par(9'h081, 8, 1), 1, 1'b1, 1'b0, 0);
    repeat (40) @(posedge clk);
    #1;
    rx1 = 1'b1;
    repeat (2*B) @(posedge clk);
    frame(1, 9'h06E, 8, 1, 1'b1, good_par(9'h06E, 8, 1), 1, 1'b1, 1'b1, LAT1);
    repeat (2*B) @(posedge clk);

    // Overrun: second word dropped while the first is unread.
    #1;
    ready1 = 1'b0;
    frame(1, 9'h011, 8, 1, 1'b1, good_par(9'h011, 8, 1), 1, 1'b1, 1'b0, 0);
    frame(1, 9'h022, 8, 1, 1'b1, good_par(9'h022, 8, 1), 1, 1'b0, 1'b0, 0);
    repeat (B) @(posedge clk);
    @(negedge clk);
    check("overrun held valid1", 32'(valid1), 1);
    check("overrun held data1", 32'(data1), 32'h11);
    check("overrun set", 32'(ovr1), 1);
    @(posedge clk);
    #1;
    ovr_clr1 = 1'b1;
    @(posedge clk);
    #1;
    ovr_clr1 = 1'b0;
    @(negedge clk);
    check("overrun cleared", 32'(ovr1), 0);
    check("data after clear", 32'(data1), 32'h11);
    @(posedge clk);
    #1;
    ready1 = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("valid1 after consume", 32'(valid1), 0);

`ifdef UART_RX_PARITY_EN
    frame(1, 9'h007, 8, 1, 1'b1, 1'b0, 1, 1'b1, 1'b1, LAT1);
    repeat (2*B) @(posedge clk);
    frame(1, 9'h007, 8, 1, 1'b1, 1'b1, 1, 1'b1, 1'b1, LAT1);
    repeat (2*B) @(posedge clk);
`endif

    // 7-bit / 2-stop receiver: build up held word and overrun, then reset mid-frame.
    #1;
    ready2 = 1'b0;
    frame(2, 9'h033, 7, 2, 1'b1, good_par(9'h033, 7, 0), 0, 1'b0, 1'b0, 0);
    frame(2, 9'h044, 7, 2, 1'b1, good_par(9'h044, 7, 0), 0, 1'b0, 1'b0, 0);
    repeat (B) @(posedge clk);
    @(negedge clk);
    check("dut2 overrun before reset", 32'(ovr2), 1);
    check("dut2 held data before reset", 32'(data2), 32'h33);
    @(posedge clk);
    #1;
    drive_bit(2, 1'b0);
    drive_bit(2, 1'b1);
    drive_bit(2, 1'b1);
    drive_bit(2, 1'b1);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midreset valid2", 32'(valid2), 0);
    check("midreset data2", 32'(data2), 0);
    check("midreset overrun2", 32'(ovr2), 0);
    check("midreset frame_err2", 32'(ferr2), 0);
    check("midreset overrun1", 32'(ovr1), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    ready2 = 1'b1;
    rx2 = 1'b1;
    repeat (6*B) @(posedge clk);
    frame(2, 9'h05A, 7, 2, 1'b1, good_par(9'h05A, 7, 0), 0, 1'b1, 1'b1, LAT2);
    repeat (2*B) @(posedge clk);

    check("dut1 words all delivered", 32'(q1.size()), 0);
    check("dut2 words all delivered", 32'(q2.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_uart_rx_os
`default_nettype wire
